// File: rtl/prog_rom_ld.sv
// Program memory with a registered fetch port and a handshaked full-image loader.
// The fetch port returns CLR_VAL while a load is in progress.
module prog_rom_ld #(
  parameter int                ADDR_W  = 4,
  parameter int                DATA_W  = 8,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] adr,
  output logic [DATA_W-1:0] dout,
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              busy
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            ptr;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic                         xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_ready  = 1'b0;
    ld_done   = 1'b0;
    busy      = 1'b0;
    xfer      = 1'b0;
    case (state)
      IDLE: if (ld_start) state_nxt = LOAD;
      LOAD: begin
        ld_ready = 1'b1;
        busy     = 1'b1;
        xfer     = ld_valid;
        if (ld_valid && (&ptr)) state_nxt = DONE;
      end
      DONE: begin
        ld_done   = 1'b1;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer wraps naturally modulo DEPTH after the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        ptr <= '0;
    else if (state == IDLE && ld_start) ptr <= '0;
    else if (xfer)                     ptr <= ptr + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= CLR_VAL;
    end else if (xfer) begin
      mem[ptr] <= ld_data;
    end
  end

  // Keyed on next state so dout already reads CLR_VAL in the first busy cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  dout <= CLR_VAL;
    else if (state_nxt == IDLE)  dout <= mem[adr];
    else                         dout <= CLR_VAL;
  end
endmodule

// File: tb/tb_prog_rom_ld.sv
// Directed bench for prog_rom_ld: scoreboarded fetch reads against a memory model,
// loads with stalls, ignored controls, and reset mid-load.
module tb_prog_rom_ld;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] adr;
  logic [7:0] dout;
  logic       ld_start, ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready, ld_done, busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] model [16];
  logic [7:0] sb_q [$];

  prog_rom_ld #(.ADDR_W(4), .DATA_W(8), .CLR_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .adr(adr), .dout(dout),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_done(ld_done), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One read per cycle; expected value queued at drive time, popped when dout lands.
  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      adr = 4'(a);
      sb_q.push_back(model[a]);
      tick();
      chk(tag, dout, sb_q.pop_front());
    end
  endtask

  // Full load of base+i; optional stall before word stall_at (with ld_start
  // wiggled, which must be ignored); optional reset after abort_after words.
  task automatic load_image(input logic [7:0] base, input int stall_at, input int abort_after);
    ld_start = 1'b1;
    ld_valid = 1'b1;              // must not write in IDLE
    ld_data  = 8'hEE;
    tick();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("ready_in_load", ld_ready, 1);
    chk("dout_forced_start", dout, 0);
    for (int i = 0; i < 16; i++) begin
      if (i == abort_after) begin
        rst_n = 1'b0;
        #1;
        chk("abort_dout", dout, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", ld_ready, 0);
        for (int k = 0; k < 16; k++) model[k] = 8'h00;
        #2 rst_n = 1'b1;
        tick();
        return;
      end
      if (i == stall_at) begin
        ld_start = 1'b1;
        repeat (3) tick();
        ld_start = 1'b0;
        chk("stall_busy", busy, 1);
        chk("stall_done", ld_done, 0);
        chk("stall_ready", ld_ready, 1);
      end
      ld_valid = 1'b1;
      ld_data  = base + 8'(i);
      adr      = 4'd3;
      tick();
      model[i] = base + 8'(i);
      ld_valid = 1'b0;
      chk("dout_forced_load", dout, 0);
      if (i < 15) begin
        chk("done_early", ld_done, 0);
      end else begin
        chk("done_pulse", ld_done, 1);
        chk("done_ready", ld_ready, 0);
        chk("done_busy", busy, 1);
      end
    end
    tick();
    chk("done_clear", ld_done, 0);
    chk("idle_busy", busy, 0);
    tick();
    chk("adr3_after_load", dout, model[3]);
  endtask

  initial begin
    rst_n = 1'b0; adr = '0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    for (int k = 0; k < 16; k++) model[k] = 8'h00;
    #12;
    chk("rst_dout", dout, 0);
    chk("rst_ready", ld_ready, 0);
    chk("rst_done", ld_done, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();
    sweep("rd_reset");

    load_image(8'h30, -1, -1);
    sweep("rd_img30");
    adr = 4'd5;
    tick();
    chk("rd_adr5_img30", dout, 8'h35);

    // ld_valid in IDLE is ignored
    ld_valid = 1'b1;
    ld_data  = 8'hFF;
    repeat (4) begin
      tick();
      chk("idle_valid_ready", ld_ready, 0);
      chk("idle_valid_busy", busy, 0);
    end
    ld_valid = 1'b0;
    sweep("rd_after_idle_valid");

    load_image(8'hA0, 8, -1);
    sweep("rd_imgA0");
    adr = 4'd5;
    tick();
    chk("rd_adr5", dout, 8'hA5);

    load_image(8'hC0, -1, 9);
    chk("post_abort_busy", busy, 0);
    sweep("rd_after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
